rv16_csr_issue: RTL and testbench

CSR instruction issue stage for the RV16 core. It sits between the decode/register-read stage and the CSR unit. It accepts one SYSTEM-opcode instruction at a time and decodes the CSR access into a single-cycle request. It then waits for the CSR unit's registered response and produces a register-file writeback of the old CSR value. Illegal encodings and unresponsive CSR accesses are flagged rather than hung.

---
 rtl/rv16_csr_issue.sv | 178 +++++++++++++++++
 tb/tb_rv16_csr_issue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv16_csr_issue.sv
// CSR instruction issue stage for the RV16 core.
// Accepts one SYSTEM-opcode instruction at a time, issues a single-cycle request to the
// CSR unit, waits for its registered response and writes the old CSR value back to rd.
// Illegal encodings raise o_illegal; a CSR unit that never answers raises o_timeout.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_instr_valid/o_instr_ready instruction handshake (ready only in IDLE)
//   i_instr, i_rs1_data        instruction word and rs1 value, sampled at accept
//   o_csr_valid/addr/wdata/op  one-cycle request to the CSR unit
//   i_csr_rdata, i_csr_ready   CSR unit response (old value)
//   o_rd_we/addr/data          register-file writeback
//   o_illegal, o_timeout       one-cycle error pulses
module rv16_csr_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_data,
  output logic        o_csr_valid,
  output logic [11:0] o_csr_addr,
  output logic [31:0] o_csr_wdata,
  output logic [2:0]  o_csr_op,
  input  logic [31:0] i_csr_rdata,
  input  logic        i_csr_ready,
  output logic        o_rd_we,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_illegal,
  output logic        o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic              instr_ready_q, instr_ready_d;
  logic              csr_valid_q, csr_valid_d;
  logic [11:0]       csr_addr_q, csr_addr_d;
  logic [31:0]       csr_wdata_q, csr_wdata_d;
  logic [2:0]        csr_op_q, csr_op_d;
  logic              rd_we_q, rd_we_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  // Instruction field decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1_field;
  logic [4:0] rd_field;
  logic       legal;
  logic [2:0] op_dec;

  assign opcode    = i_instr[6:0];
  assign funct3    = i_instr[14:12];
  assign rs1_field = i_instr[19:15];
  assign rd_field  = i_instr[11:7];
  // funct3 of 000 or 100 is not a CSR access
  assign legal     = (opcode == 7'b1110011) && (funct3[1:0] != 2'b00);

  // Set/clear with x0 or zimm 0 must not write the CSR, so degrade to read-only
  always_comb begin
    op_dec = {1'b0, funct3[1:0]};
    if (funct3[1] && (rs1_field == 5'd0)) begin
      op_dec = 3'b000;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    csr_valid_d = 1'b0;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_op_d    = csr_op_q;
    rd_we_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    illegal_d   = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_instr_valid) begin
          if (legal) begin
            state_d     = StIssue;
            csr_valid_d = 1'b1;
            csr_addr_d  = i_instr[31:20];
            csr_op_d    = op_dec;
            csr_wdata_d = funct3[2] ? {27'd0, rs1_field} : i_rs1_data;
            rd_d        = rd_field;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // A response in the expiry cycle still wins over the timeout
        if (i_csr_ready) begin
          state_d   = StWb;
          rd_data_d = i_csr_rdata;
          rd_addr_d = rd_q;
          rd_we_d   = (rd_q != 5'd0);
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    instr_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rd_q          <= 5'd0;
      instr_ready_q <= 1'b1;
      csr_valid_q   <= 1'b0;
      csr_addr_q    <= 12'd0;
      csr_wdata_q   <= 32'd0;
      csr_op_q      <= 3'd0;
      rd_we_q       <= 1'b0;
      rd_addr_q     <= 5'd0;
      rd_data_q     <= 32'd0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      instr_ready_q <= instr_ready_d;
      csr_valid_q   <= csr_valid_d;
      csr_addr_q    <= csr_addr_d;
      csr_wdata_q   <= csr_wdata_d;
      csr_op_q      <= csr_op_d;
      rd_we_q       <= rd_we_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
    end
  end

  assign o_instr_ready = instr_ready_q;
  assign o_csr_valid   = csr_valid_q;
  assign o_csr_addr    = csr_addr_q;
  assign o_csr_wdata   = csr_wdata_q;
  assign o_csr_op      = csr_op_q;
  assign o_rd_we       = rd_we_q;
  assign o_rd_addr     = rd_addr_q;
  assign o_rd_data     = rd_data_q;
  assign o_illegal     = illegal_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_rv16_csr_issue.sv
// Scoreboard bench for rv16_csr_issue: the driver pushes expected requests, writebacks and
// pulses (tagged with the cycle they must appear in); a monitor pops and compares them.
module tb_rv16_csr_issue;

  localparam int unsigned T = 16;

  logic        clk;
  logic        rst_n;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [31:0] i_instr;
  logic [31:0] i_rs1_data;
  logic        o_csr_valid;
  logic [11:0] o_csr_addr;
  logic [31:0] o_csr_wdata;
  logic [2:0]  o_csr_op;
  logic [31:0] i_csr_rdata;
  logic        i_csr_ready;
  logic        o_rd_we;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_illegal;
  logic        o_timeout;

  rv16_csr_issue #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr       (i_instr),
    .i_rs1_data    (i_rs1_data),
    .o_csr_valid   (o_csr_valid),
    .o_csr_addr    (o_csr_addr),
    .o_csr_wdata   (o_csr_wdata),
    .o_csr_op      (o_csr_op),
    .i_csr_rdata   (i_csr_rdata),
    .i_csr_ready   (i_csr_ready),
    .o_rd_we       (o_rd_we),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_illegal     (o_illegal),
    .o_timeout     (o_timeout)
  );

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
  } req_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   illegal_q[$];
  int   timeout_q[$];

  int cyc;
  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: compares every presented output event against the scoreboard
  initial begin
    req_t r;
    wb_t  w;
    int   p;
    forever begin
      @(negedge clk);
      if (o_csr_valid) begin
        if (req_q.size() == 0) fail("csr_valid");
        else begin
          r = req_q.pop_front();
          check("req_cycle", cyc, r.cyc);
          check("req_addr", {20'd0, o_csr_addr}, {20'd0, r.addr});
          check("req_op", {29'd0, o_csr_op}, {29'd0, r.op});
          check("req_wdata", o_csr_wdata, r.wdata);
        end
      end
      if (o_rd_we) begin
        if (wb_q.size() == 0) fail("rd_we");
        else begin
          w = wb_q.pop_front();
          check("wb_cycle", cyc, w.cyc);
          check("wb_rd", {27'd0, o_rd_addr}, {27'd0, w.rd});
          check("wb_data", o_rd_data, w.data);
        end
      end
      if (o_illegal) begin
        if (illegal_q.size() == 0) fail("illegal");
        else begin
          p = illegal_q.pop_front();
          check("illegal_cycle", cyc, p);
        end
      end
      if (o_timeout) begin
        if (timeout_q.size() == 0) fail("timeout");
        else begin
          p = timeout_q.pop_front();
          check("timeout_cycle", cyc, p);
        end
      end
    end
  end

  // One CSR access; the response arrives in cycle 2+delay, delay >= T means never
  task automatic do_csr(input logic [31:0] instr, input logic [31:0] rs1,
                        input logic [31:0] rdata, input int delay,
                        input logic [11:0] exp_addr, input logic [2:0] exp_op,
                        input logic [31:0] exp_wdata, input logic [4:0] exp_rd,
                        input logic exp_we);
    int t0;
    @(negedge clk);
    t0 = cyc;
    i_instr_valid = 1'b1;
    i_instr       = instr;
    i_rs1_data    = rs1;
    req_q.push_back('{cyc: t0 + 1, addr: exp_addr, wdata: exp_wdata, op: exp_op});
    if (delay < int'(T)) begin
      if (exp_we) wb_q.push_back('{cyc: t0 + 3 + delay, rd: exp_rd, data: rdata});
    end else begin
      timeout_q.push_back(t0 + int'(T) + 2);
    end
    @(negedge clk);
    i_instr_valid = 1'b0;
    check("busy_not_ready", {31'd0, o_instr_ready}, 32'd0);
    if (delay < int'(T)) begin
      repeat (delay + 1) @(negedge clk);
      i_csr_ready = 1'b1;
      i_csr_rdata = rdata;
      @(negedge clk);
      i_csr_ready = 1'b0;
      i_csr_rdata = 32'd0;
      @(negedge clk);
    end else begin
      repeat (T + 1) @(negedge clk);
    end
    check("ready_after", {31'd0, o_instr_ready}, 32'd1);
  endtask

  task automatic do_illegal(input logic [31:0] instr);
    @(negedge clk);
    check("illegal_ready", {31'd0, o_instr_ready}, 32'd1);
    i_instr_valid = 1'b1;
    i_instr       = instr;
    i_rs1_data    = 32'h5555_AAAA;
    illegal_q.push_back(cyc + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_ready"}, {31'd0, o_instr_ready}, 32'd1);
    check({tag, "_csr_valid"}, {31'd0, o_csr_valid}, 32'd0);
    check({tag, "_csr_addr"}, {20'd0, o_csr_addr}, 32'd0);
    check({tag, "_csr_wdata"}, o_csr_wdata, 32'd0);
    check({tag, "_csr_op"}, {29'd0, o_csr_op}, 32'd0);
    check({tag, "_rd_we"}, {31'd0, o_rd_we}, 32'd0);
    check({tag, "_rd_addr"}, {27'd0, o_rd_addr}, 32'd0);
    check({tag, "_rd_data"}, o_rd_data, 32'd0);
    check({tag, "_illegal"}, {31'd0, o_illegal}, 32'd0);
    check({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    i_instr_valid = 1'b0;
    i_instr       = 32'd0;
    i_rs1_data    = 32'd0;
    i_csr_rdata   = 32'd0;
    i_csr_ready   = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CSRRW x5, 0x305, x6
    do_csr(32'h305312F3, 32'h0000_0100, 32'h0, 0, 12'h305, 3'b001, 32'h100, 5'd5, 1'b1);
    // CSRRS x7, 0x300, x0: read-only
    do_csr(32'h300023F3, 32'h0, 32'h8, 0, 12'h300, 3'b000, 32'h0, 5'd7, 1'b1);
    // CSRRCI x1, 0x304, 5: zimm must replace rs1 data
    do_csr(32'h3042F0F3, 32'hFFFF_FFFF, 32'h1234, 1, 12'h304, 3'b011, 32'h5, 5'd1, 1'b1);
    // CSRRW x0, 0x340, x1: no writeback
    do_csr(32'h34009073, 32'hDEAD_BEEF, 32'hCAFE, 0, 12'h340, 3'b001, 32'hDEAD_BEEF,
           5'd0, 1'b0);
    // CSRRSI x3, 0x341, 3 with ready in the final WAIT cycle: ready wins
    do_csr(32'h3411E1F3, 32'h0, 32'hA5A5, int'(T) - 1, 12'h341, 3'b010, 32'h3, 5'd3, 1'b1);

    // Back-to-back illegal accepts: ADDI, funct3 000, funct3 100
    do_illegal(32'h0000_0013);
    do_illegal(32'h0000_0073);
    do_illegal(32'h0000_4073);
    @(negedge clk);
    i_instr_valid = 1'b0;
    check("illegal_ready_end", {31'd0, o_instr_ready}, 32'd1);
    repeat (2) @(negedge clk);

    // No response: timeout in cycle T+2
    do_csr(32'h305312F3, 32'h77, 32'h0, int'(T), 12'h305, 3'b001, 32'h77, 5'd5, 1'b1);

    // No response, reset during cycle 5
    @(negedge clk);
    t0 = cyc;
    i_instr_valid = 1'b1;
    i_instr       = 32'h305312F3;
    i_rs1_data    = 32'h99;
    req_q.push_back('{cyc: t0 + 1, addr: 12'h305, wdata: 32'h99, op: 3'b001});
    @(negedge clk);
    i_instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_csr(32'h300023F3, 32'h0, 32'h42, 0, 12'h300, 3'b000, 32'h0, 5'd7, 1'b1);

    repeat (T + 4) @(negedge clk);
    check("req_q_empty", req_q.size(), 32'd0);
    check("wb_q_empty", wb_q.size(), 32'd0);
    check("illegal_q_empty", illegal_q.size(), 32'd0);
    check("timeout_q_empty", timeout_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
